// File: rtl/gh_video_pkg.sv
// Shared definitions for the note video generator.
// Holds the 640x480@60 raster timing, the bit layout of a packed note
// position word, and a helper that pulls the x/y fields out of that word.
package gh_video_pkg;

    // Horizontal timing in pixels.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Position word layout: x = [10:0], y = [21:12]; other bits are ignored.
    localparam int POS_X_LSB = 0;
    localparam int POS_X_MSB = 10;
    localparam int POS_Y_LSB = 12;
    localparam int POS_Y_MSB = 21;

    // Counter widths double as the no-wrap widths of the box edge sums.
    localparam int HCNT_W = 12;
    localparam int VCNT_W = 11;

    typedef struct packed {
        logic [POS_Y_MSB-POS_Y_LSB:0] y;
        logic [POS_X_MSB-POS_X_LSB:0] x;
    } note_pos_t;

    function automatic note_pos_t extract_pos(input logic [23:0] word);
        note_pos_t p;
        p.x = word[POS_X_MSB:POS_X_LSB];
        p.y = word[POS_Y_MSB:POS_Y_LSB];
        return p;
    endfunction

endpackage

// File: rtl/gh_note_box.sv
// Hit test for one note box.
// Latches mask/position at frame start and reports whether the current
// raster position (hcnt, vcnt) falls inside the NOTE_W x NOTE_H box.
// Ports:
//   clk, rst    pixel clock, asynchronous active-high reset
//   latch       frame start: capture mask and pos this cycle
//   mask, pos   live note enable and origin
//   hcnt, vcnt  raster position being evaluated
//   hit         combinational in-box flag for (hcnt, vcnt)
module gh_note_box
    import gh_video_pkg::*;
#(
    parameter int NOTE_W = 16,
    parameter int NOTE_H = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              latch,
    input  logic              mask,
    input  note_pos_t         pos,
    input  logic [HCNT_W-1:0] hcnt,
    input  logic [VCNT_W-1:0] vcnt,
    output logic              hit
);

    logic      mask_q;
    note_pos_t pos_q;

    // NOTE: the frame registers are plain flops, so they take the reset;
    // a cleared mask guarantees nothing is drawn before the first latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= 1'b0;
            pos_q  <= '0;
        end else if (latch) begin
            mask_q <= mask;
            pos_q  <= pos;
        end
    end

    // Pixel (0,0) is evaluated on the same edge that latches, so it must see
    // the incoming values; every other pixel uses the frame registers.
    logic              eff_mask;
    note_pos_t         eff_pos;
    logic [HCNT_W-1:0] x_lo, x_hi;
    logic [VCNT_W-1:0] y_lo, y_hi;

    assign eff_mask = latch ? mask : mask_q;
    assign eff_pos  = latch ? pos  : pos_q;

    // Edge sums are one bit wider than the fields, so they never wrap.
    assign x_lo = {1'b0, eff_pos.x};
    assign x_hi = x_lo + HCNT_W'(NOTE_W);
    assign y_lo = {1'b0, eff_pos.y};
    assign y_hi = y_lo + VCNT_W'(NOTE_H);

    assign hit = eff_mask && (hcnt >= x_lo) && (hcnt < x_hi)
                          && (vcnt >= y_lo) && (vcnt < y_hi);

endmodule

// File: rtl/gh_note_video_gen.sv
// Monochrome note video generator.
// Runs a VGA-style raster and draws up to five note boxes (G,R,Y,B,O).
// Ports:
//   CLK, RST        pixel clock, asynchronous active-high reset
//   Enable          run the raster; low holds it at (0,0)
//   NoteMask        {O,B,Y,R,G} draw enables, latched at frame start
//   *Pos            box origins, x=[10:0], y=[21:12], latched at frame start
//   HSync, VSync    active-high syncs
//   VDE             active video
//   Pixel           1 = note colour
//   FrameStart      pulse aligned with pixel (0,0)
//   FrameCount      completed frames, wrapping
// All outputs are registered one cycle behind the counter state.
// Raster timing parameters default to the package values.
module gh_note_video_gen
    import gh_video_pkg::*;
#(
    parameter int NOTE_W   = 16,
    parameter int NOTE_H   = 8,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC_W = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SYNC_W = V_SYNC,
    parameter int V_BACK   = V_BP
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        Enable,
    input  logic [4:0]  NoteMask,
    input  logic [23:0] GreenPos,
    input  logic [23:0] RedPos,
    input  logic [23:0] YellowPos,
    input  logic [23:0] BluePos,
    input  logic [23:0] OrangePos,
    output logic        HSync,
    output logic        VSync,
    output logic        VDE,
    output logic        Pixel,
    output logic        FrameStart,
    output logic [15:0] FrameCount
);

    localparam logic [HCNT_W-1:0] H_ACT_END  = HCNT_W'(H_ACT);
    localparam logic [HCNT_W-1:0] H_SYNC_ON  = HCNT_W'(H_ACT + H_FRONT);
    localparam logic [HCNT_W-1:0] H_SYNC_OFF = HCNT_W'(H_ACT + H_FRONT + H_SYNC_W);
    localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_ACT + H_FRONT + H_SYNC_W + H_BACK - 1);
    localparam logic [VCNT_W-1:0] V_ACT_END  = VCNT_W'(V_ACT);
    localparam logic [VCNT_W-1:0] V_SYNC_ON  = VCNT_W'(V_ACT + V_FRONT);
    localparam logic [VCNT_W-1:0] V_SYNC_OFF = VCNT_W'(V_ACT + V_FRONT + V_SYNC_W);
    localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_ACT + V_FRONT + V_SYNC_W + V_BACK - 1);

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              started;   // a frame has begun since Enable rose
    logic              at_origin;
    logic              latch;
    logic              active;
    logic [4:0]        hit;
    note_pos_t [4:0]   live_pos;

    // Position bits outside the x/y fields are don't-care.
    logic unused_pos_bits;
    assign unused_pos_bits = ^{GreenPos[23:22],  GreenPos[11],
                               RedPos[23:22],    RedPos[11],
                               YellowPos[23:22], YellowPos[11],
                               BluePos[23:22],   BluePos[11],
                               OrangePos[23:22], OrangePos[11]};

    assign live_pos = {extract_pos(OrangePos), extract_pos(BluePos),
                       extract_pos(YellowPos), extract_pos(RedPos),
                       extract_pos(GreenPos)};

    assign at_origin = (hcnt == '0) && (vcnt == '0);
    assign latch     = Enable && at_origin;
    assign active    = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);

    for (genvar k = 0; k < 5; k++) begin : g_box
        gh_note_box #(
            .NOTE_W (NOTE_W),
            .NOTE_H (NOTE_H)
        ) u_box (
            .clk   (CLK),
            .rst   (RST),
            .latch (latch),
            .mask  (NoteMask[k]),
            .pos   (live_pos[k]),
            .hcnt  (hcnt),
            .vcnt  (vcnt),
            .hit   (hit[k])
        );
    end

    // NOTE: all state here uses non-blocking assignments so every output is
    // computed from the same pre-edge counter values and stays aligned.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hcnt       <= '0;
            vcnt       <= '0;
            started    <= 1'b0;
            HSync      <= 1'b0;
            VSync      <= 1'b0;
            VDE        <= 1'b0;
            Pixel      <= 1'b0;
            FrameStart <= 1'b0;
            FrameCount <= '0;
        end else if (!Enable) begin
            // Hold at the origin; a partly drawn frame is simply dropped.
            hcnt       <= '0;
            vcnt       <= '0;
            started    <= 1'b0;
            HSync      <= 1'b0;
            VSync      <= 1'b0;
            VDE        <= 1'b0;
            Pixel      <= 1'b0;
            FrameStart <= 1'b0;
        end else begin
            HSync      <= (hcnt >= H_SYNC_ON) && (hcnt < H_SYNC_OFF);
            VSync      <= (vcnt >= V_SYNC_ON) && (vcnt < V_SYNC_OFF);
            VDE        <= active;
            Pixel      <= active && (|hit);
            FrameStart <= at_origin;

            // Reaching the origin again means the previous frame completed.
            if (at_origin) begin
                started <= 1'b1;
                if (started)
                    FrameCount <= FrameCount + 16'd1;
            end

            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VCNT_W'(1);
            end else begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gh_note_video_gen.sv
// Self-checking bench for gh_note_video_gen.
// A reduced raster instance is checked every cycle against an arithmetic
// model; a full-timing instance pins the real line timing over two lines.
module tb_gh_note_video_gen;

    localparam int NW = 16, NH = 8;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;  // 80
    localparam int VA = 40, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;  // 46
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [4:0]  mask = '0;
    logic [23:0] pos [5];

    logic        hs, vs, vde, pix, fs;
    logic [15:0] fc;
    logic        f_hs, f_vs, f_vde, f_pix, f_fs;
    logic [15:0] f_fc;

    int total = 0;
    int bad   = 0;
    bit full_done = 0;

    always #5 clk = ~clk;

    gh_note_video_gen #(
        .NOTE_W(NW), .NOTE_H(NH),
        .H_ACT(HA), .H_FRONT(HF), .H_SYNC_W(HS), .H_BACK(HB),
        .V_ACT(VA), .V_FRONT(VF), .V_SYNC_W(VS), .V_BACK(VB)
    ) dut (
        .CLK(clk), .RST(rst), .Enable(en), .NoteMask(mask),
        .GreenPos(pos[0]), .RedPos(pos[1]), .YellowPos(pos[2]),
        .BluePos(pos[3]), .OrangePos(pos[4]),
        .HSync(hs), .VSync(vs), .VDE(vde), .Pixel(pix),
        .FrameStart(fs), .FrameCount(fc)
    );

    gh_note_video_gen dut_full (
        .CLK(clk), .RST(rst), .Enable(en), .NoteMask(mask),
        .GreenPos(pos[0]), .RedPos(pos[1]), .YellowPos(pos[2]),
        .BluePos(pos[3]), .OrangePos(pos[4]),
        .HSync(f_hs), .VSync(f_vs), .VDE(f_vde), .Pixel(f_pix),
        .FrameStart(f_fs), .FrameCount(f_fc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pos24(input int x, input int y, input bit junk);
        return {{2{junk}}, 10'(y), junk, 11'(x)};
    endfunction

    // ---------------- model of the reduced instance ----------------
    int       mh = 0, mv = 0, m_fc = 0;
    bit       m_started = 0;
    bit [4:0] m_mask = '0;
    int       m_x [5];
    int       m_y [5];
    logic     e_hs, e_vs, e_vde, e_pix, e_fs;

    always begin
        @(posedge clk);
        if (rst) begin
            mh = 0; mv = 0; m_fc = 0; m_started = 0; m_mask = '0;
            for (int k = 0; k < 5; k++) begin m_x[k] = 0; m_y[k] = 0; end
            {e_hs, e_vs, e_vde, e_pix, e_fs} = '0;
        end else if (!en) begin
            mh = 0; mv = 0; m_started = 0;
            {e_hs, e_vs, e_vde, e_pix, e_fs} = '0;
        end else begin
            if (mh == 0 && mv == 0) begin
                m_mask = mask;
                for (int k = 0; k < 5; k++) begin
                    m_x[k] = int'(pos[k][10:0]);
                    m_y[k] = int'(pos[k][21:12]);
                end
                if (m_started) m_fc = (m_fc + 1) % 65536;
                m_started = 1;
            end
            e_fs  = (mh == 0 && mv == 0);
            e_hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
            e_vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
            e_vde = (mh < HA) && (mv < VA);
            e_pix = 1'b0;
            for (int k = 0; k < 5; k++)
                if (m_mask[k] && mh >= m_x[k] && mh < m_x[k] + NW
                              && mv >= m_y[k] && mv < m_y[k] + NH)
                    e_pix = 1'b1;
            e_pix = e_pix & e_vde;
            mh++;
            if (mh == HT) begin
                mh = 0; mv++;
                if (mv == VT) mv = 0;
            end
        end
        #1;
        check("hsync", 32'(hs), 32'(e_hs));
        check("vsync", 32'(vs), 32'(e_vs));
        check("vde", 32'(vde), 32'(e_vde));
        check("pixel", 32'(pix), 32'(e_pix));
        check("frame_start", 32'(fs), 32'(e_fs));
        check("frame_count", 32'(fc), 32'(m_fc));
    end

    // ---------------- full-timing line checks ----------------
    initial begin
        int t_fs = -1, t_hs_rise1 = -1, t_hs_rise2 = -1, t_hs_fall = -1, t_vde_fall = -1;
        logic p_hs = 1'b0, p_vde = 1'b0;
        @(negedge rst);
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (f_fs === 1'b1 && t_fs < 0) t_fs = c;
            if (f_hs === 1'b1 && !p_hs) begin
                if (t_hs_rise1 < 0) t_hs_rise1 = c;
                else if (t_hs_rise2 < 0) t_hs_rise2 = c;
            end
            if (f_hs !== 1'b1 && p_hs && t_hs_fall < 0) t_hs_fall = c;
            if (f_vde !== 1'b1 && p_vde && t_vde_fall < 0) t_vde_fall = c;
            p_hs  = (f_hs === 1'b1);
            p_vde = (f_vde === 1'b1);
        end
        check("full_first_fs", 32'(t_fs), 32'd0);
        check("full_vde_fall", 32'(t_vde_fall), 32'd640);
        check("full_hsync_rise", 32'(t_hs_rise1), 32'd656);
        check("full_hsync_fall", 32'(t_hs_fall), 32'd752);
        check("full_line_period", 32'(t_hs_rise2 - t_hs_rise1), 32'd800);
        full_done = 1;
    end

    // ---------------- directed sequence ----------------
    task automatic wait_fs();
        bit ok = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            if (fs === 1'b1) begin ok = 1; break; end
        end
        if (!ok) check("wait_frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Counts Pixel over one frame starting at the current (FrameStart) sample.
    task automatic frame_ones(input int chg_at, input logic [4:0] chg_mask, output int ones);
        ones = int'(pix === 1'b1);
        for (int i = 1; i < FRAME; i++) begin
            @(posedge clk); #1;
            ones += int'(pix === 1'b1);
            if (i == chg_at) mask = chg_mask;
        end
    endtask

    initial begin
        int n;
        bit ok;
        for (int k = 0; k < 5; k++) pos[k] = '0;
        pos[0] = pos24(20, 10, 1'b1);   // ignored bits set on purpose
        mask   = 5'b00001;
        en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({hs, vs, vde, pix, fs}), 32'd0);
        check("reset_frame_count", 32'(fc), 32'd0);

        // Frame 0: green box only.
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("first_fs_after_reset", 32'(fs), 32'd1);
        frame_ones(-1, 5'b0, n);
        check("green_ones", 32'(n), 32'd128);

        // Frame 1: orange clipped at the right edge.
        mask = 5'b10000; pos[4] = pos24(56, 5, 1'b0);
        wait_fs();
        check("fc_frame1", 32'(fc), 32'd1);
        frame_ones(-1, 5'b0, n);
        check("orange_clip_ones", 32'(n), 32'd64);

        // Frame 2: red clipped at the bottom.
        mask = 5'b00010; pos[1] = pos24(0, 36, 1'b0);
        wait_fs();
        check("fc_frame2", 32'(fc), 32'd2);
        frame_ones(-1, 5'b0, n);
        check("red_clip_ones", 32'(n), 32'd64);

        // Frame 3: mask changed mid-frame has no effect; frame 4 shows all.
        mask = 5'b00001; pos[2] = pos24(40, 0, 1'b0); pos[3] = pos24(28, 14, 1'b0);
        wait_fs();
        check("fc_frame3", 32'(fc), 32'd3);
        frame_ones(20 * HT, 5'b11111, n);
        check("mask_change_current", 32'(n), 32'd128);
        wait_fs();
        check("fc_frame4", 32'(fc), 32'd4);
        frame_ones(-1, 5'b0, n);
        check("all_five_ones", 32'(n), 32'd480);

        // Drop Enable mid-frame for 10 cycles.
        wait_fs();
        check("fc_frame5", 32'(fc), 32'd5);
        repeat (20 * HT) begin @(posedge clk); #1; end
        en = 1'b0;
        @(posedge clk); #1;
        check("enable_low_outputs", 32'({hs, vs, vde, pix, fs}), 32'd0);
        check("enable_low_fc", 32'(fc), 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        check("enable_low_fc_hold", 32'(fc), 32'd5);
        en = 1'b1;
        @(posedge clk); #1;
        check("enable_restart_fs", 32'(fs), 32'd1);
        check("enable_restart_fc", 32'(fc), 32'd5);
        frame_ones(-1, 5'b0, n);
        check("restart_ones", 32'(n), 32'd480);
        @(posedge clk); #1;
        check("restart_next_fs", 32'(fs), 32'd1);
        check("restart_next_fc", 32'(fc), 32'd6);

        // Reset during VSync.
        ok = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #1;
            if (vs === 1'b1) begin ok = 1; break; end
        end
        check("vsync_seen", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_vsync", 32'(vs), 32'd0);
        check("async_reset_outputs", 32'({hs, vde, pix, fs}), 32'd0);
        check("async_reset_fc", 32'(fc), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_fs", 32'(fs), 32'd1);
        check("post_reset_fc", 32'(fc), 32'd0);
        frame_ones(-1, 5'b0, n);
        check("post_reset_ones", 32'(n), 32'd480);
        @(posedge clk); #1;
        check("post_reset_fc_next", 32'(fc), 32'd1);

        for (int i = 0; i < 100 && !full_done; i++) @(posedge clk);
        check("full_checks_done", 32'(full_done), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gh_note_video_gen.md
GH_NOTE_VIDEO_GEN -- requirements
Module: gh_note_video_gen

Interface
REQ-001 Parameter NOTE_W, default 16, meaning the note box width in pixels (1..64).
REQ-002 Parameter NOTE_H, default 8, meaning the note box height in lines (1..64).
REQ-003 CLK  input  1  pixel clock, one pixel per cycle; the block has one clock, and all logic is on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Enable  input  1  run the raster; when low, the raster is held at its origin.
REQ-006 NoteMask  input  5  notes to draw, ordered {O,B,Y,R,G}; sampled at frame start.
REQ-007 GreenPos  input  24  green note box origin: x = [10:0], y = [21:12]; other bits are ignored.
REQ-008 RedPos  input  24  red note box origin; same field layout as GreenPos.
REQ-009 YellowPos  input  24  yellow note box origin; same field layout as GreenPos.
REQ-010 BluePos  input  24  blue note box origin; same field layout as GreenPos.
REQ-011 OrangePos  input  24  orange note box origin; same field layout as GreenPos.
REQ-012 HSync  output  1  horizontal sync, active-high.
REQ-013 VSync  output  1  vertical sync, active-high.
REQ-014 VDE  output  1  active video region.
REQ-015 Pixel  output  1  monochrome pixel; 1 means note colour.
REQ-016 FrameStart  output  1  one-cycle pulse that coincides with pixel (0,0).
REQ-017 FrameCount  output  16  number of completed frames; wraps at 0xFFFF->0.

Function
REQ-018 hcnt SHALL count 0..H_TOTAL-1 (800) and then wrap to 0; vcnt SHALL increment only on an hcnt wrap, count 0..V_TOTAL-1 (525) and then wrap to 0.
REQ-019 Timing: the active region is hcnt<640 and vcnt<480; HSync is high for hcnt 656..751; VSync is high for vcnt 490..491, across whole lines.
REQ-020 All outputs SHALL be registered; outputs in cycle n+1 reflect counter state (hcnt,vcnt) at cycle n, with HSync, VSync, VDE, Pixel and FrameStart mutually aligned.
REQ-021 At hcnt=0 and vcnt=0, NoteMask and all five positions SHALL be latched into frame registers; input changes mid-frame have no effect until the next frame start.
REQ-022 For note k, hit_k = mask_k AND (x_k <= hcnt < x_k+NOTE_W) AND (y_k <= vcnt < y_k+NOTE_H); comparisons use 12-bit x and 11-bit y sums, with no wrap.
REQ-023 Pixel SHALL equal VDE AND (hit_G OR hit_R OR hit_Y OR hit_B OR hit_O); overlapping boxes OR together; boxes extending past the active region are clipped.
REQ-024 FrameCount SHALL increment on the cycle after the vcnt and hcnt wrap to (0,0), excluding the first frame after Enable rises.
REQ-025 Enable low: counters SHALL be forced to (0,0), and HSync, VSync, VDE, Pixel and FrameStart SHALL be 0 from the next cycle; FrameCount holds its value.
REQ-026 Enable rising: the raster SHALL start at (0,0), FrameStart SHALL assert on the first output cycle, and the latch in REQ-021 SHALL occur.
REQ-027 Enable falling mid-frame SHALL abandon the frame without incrementing FrameCount.

Reset
REQ-028 While RST is high: hcnt=0, vcnt=0, frame registers=0, and all outputs (including FrameCount) are 0.
REQ-029 After RST deasserts, if Enable is high, the raster SHALL start as in REQ-026 on the first CLK edge.
REQ-030 RST asserted mid-frame SHALL clear all state immediately, asynchronously, with no partial pulse after release.

Structure
REQ-031 Package gh_video_pkg SHALL hold the timing constants H_ACTIVE, H_FP, H_SYNC, H_BP, H_TOTAL, the corresponding V_* constants, and the position field bit ranges.
REQ-032 Sub-module gh_note_box SHALL implement the REQ-022 hit test and its latch; it is instantiated five times.

Verification
REQ-033 Reset release with Enable=1: FrameStart at the first output; HSync rises after 656 active+porch cycles; line period 800; VSync high for 2 lines starting at line 490.
REQ-034 Latch Green={y=100,x=200} with mask=00001 and NOTE_W=16, NOTE_H=8: Pixel=1 only for lines 100..107 and columns 200..215, giving exactly 128 ones per frame.
REQ-035 Orange x=632: Pixel is clipped to columns 632..639 (8 columns); Red x=0 with y=476 yields 4 lines only.
REQ-036 Change NoteMask from 00001 to 11111 at line 240: the current frame is unchanged, and the next frame shows all five boxes.
REQ-037 Drop Enable at line 300 for 10 cycles, then raise it: all outputs are 0 within 1 cycle, FrameCount is unchanged, and FrameStart follows on the next cycle.
REQ-038 Assert RST at line 491 during VSync: VSync falls asynchronously, FrameCount=0, and the raster restarts at (0,0).
